// File: rtl/btc_miner_top.sv
// btc_miner_top: SHA-256d proof-of-work nonce search over an 80-byte block header.
// Ports: clk, reset (async, active-high), start (sampled in IDLE/DONE),
//   blockHeader_noNonce[607:0] (byte 0 in [607:600]), target[255:0],
//   digest[255:0] (H0 in [255:224]), golden_nonce[31:0], finish (level), found.
module btc_miner_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [607:0] blockHeader_noNonce,
    input  logic [255:0] target,
    output logic [255:0] digest,
    output logic [31:0]  golden_nonce,
    output logic         finish,
    output logic         found
);
    typedef enum logic [2:0] {IDLE, MID, H1, H2, CHECK, DONE} state_t;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Second block of hash 1: header tail, nonce little-endian, padding, length 640.
    function automatic logic [511:0] blk1(input logic [95:0] tail, input logic [31:0] n);
        return {tail, n[7:0], n[15:8], n[23:16], n[31:24], 32'h80000000, 320'd0, 32'd640};
    endfunction

    function automatic logic [511:0] blk2(input logic [255:0] h);
        return {h, 32'h80000000, 192'd0, 32'd256};
    endfunction

    state_t state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [31:0]  nonce_q, nonce_d, golden_q, golden_d;
    logic [95:0]  tail_q, tail_d;
    logic [255:0] target_q, target_d, mid_q, mid_d, chain_q, chain_d, work_q, work_d;
    logic [255:0] res_q, res_d, digest_q, digest_d;
    logic [511:0] w_q, w_d;
    logic         finish_q, finish_d, found_q, found_d;
    logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, wn;
    logic [255:0] round, sum;
    logic         hit, last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nonce_q  <= '0;
            golden_q <= '0;
            tail_q   <= '0;
            target_q <= '0;
            mid_q    <= '0;
            chain_q  <= '0;
            work_q   <= '0;
            res_q    <= '0;
            digest_q <= '0;
            w_q      <= '0;
            finish_q <= 1'b0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nonce_q  <= nonce_d;
            golden_q <= golden_d;
            tail_q   <= tail_d;
            target_q <= target_d;
            mid_q    <= mid_d;
            chain_q  <= chain_d;
            work_q   <= work_d;
            res_q    <= res_d;
            digest_q <= digest_d;
            w_q      <= w_d;
            finish_q <= finish_d;
            found_q  <= found_d;
        end
    end

    assign hit  = res_q <= target_q;
    assign last = &nonce_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? MID : state_q;
            MID:        state_d = (cnt_q == 7'd64) ? H1 : MID;
            H1:         state_d = (cnt_q == 7'd64) ? H2 : H1;
            H2:         state_d = (cnt_q == 7'd64) ? CHECK : H2;
            CHECK:      state_d = (hit || last) ? DONE : H1;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        {a, b, c, d, e, f, g, h} = work_q;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[cnt_q[5:0]] + w_q[511:480];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        round = {t1 + t2, a, b, c, d + t1, e, f, g};
        // Rolling 16-word schedule: words 0, 1, 9, 14 are W[t], W[t+1], W[t+9], W[t+14].
        wn = (rotr(w_q[63:32], 17) ^ rotr(w_q[63:32], 19) ^ (w_q[63:32] >> 10)) + w_q[223:192]
           + (rotr(w_q[479:448], 7) ^ rotr(w_q[479:448], 18) ^ (w_q[479:448] >> 3)) + w_q[511:480];
        for (int i = 0; i < 8; i++) sum[32*i +: 32] = chain_q[32*i +: 32] + work_q[32*i +: 32];
        cnt_d    = cnt_q;
        nonce_d  = nonce_q;
        golden_d = golden_q;
        tail_d   = tail_q;
        target_d = target_q;
        mid_d    = mid_q;
        chain_d  = chain_q;
        work_d   = work_q;
        res_d    = res_q;
        digest_d = digest_q;
        w_d      = w_q;
        finish_d = finish_q;
        found_d  = found_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                tail_d   = blockHeader_noNonce[95:0];
                target_d = target;
                nonce_d  = '0;
                finish_d = 1'b0;
                found_d  = 1'b0;
                work_d   = IV;
                chain_d  = IV;
                w_d      = blockHeader_noNonce[607:96];
                cnt_d    = '0;
            end
            MID, H1, H2: if (cnt_q != 7'd64) begin
                work_d = round;
                w_d    = {w_q[479:0], wn};
                cnt_d  = cnt_q + 7'd1;
            end else begin
                cnt_d = '0;
                case (state_q)
                    MID: begin
                        mid_d   = sum;
                        work_d  = sum;
                        chain_d = sum;
                        w_d     = blk1(tail_q, nonce_q);
                    end
                    H1: begin
                        work_d  = IV;
                        chain_d = IV;
                        w_d     = blk2(sum);
                    end
                    default: res_d = sum;
                endcase
            end
            CHECK: if (hit || last) begin
                digest_d = res_q;
                golden_d = nonce_q;
                found_d  = hit;
                finish_d = 1'b1;
            end else begin
                nonce_d = nonce_q + 32'd1;
                work_d  = mid_q;
                chain_d = mid_q;
                w_d     = blk1(tail_q, nonce_q + 32'd1);
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        digest       = digest_q;
        golden_nonce = golden_q;
        finish       = finish_q;
        found        = found_q;
    end
endmodule

// File: tb/tb_btc_miner_top.sv
// tb_btc_miner_top: vector table plus hand sequences against a software SHA-256d model.
module tb_btc_miner_top;
    localparam logic [607:0] HDR = 608'h0100000081cd02ab7e569e8bcd9317e2fe99f2de44d49ab2b8851ba4a308000000000000e320b6c2fffc8d750423db8b1eb942ae710e951ed797f7affc8892b0f1fc122bc7f5d74df2b9441a;
    localparam logic [255:0] D0 = 256'hd883d7a3b814e3eace8a16e2f733c55780f87df3accdb85ee64a8241890f83da;
    localparam logic [255:0] ONES = '1;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [255:0] tgt;
        int           hold;
        logic [255:0] digest;
        logic [31:0]  nonce;
        logic         found;
        int           cycles;
    } vec_t;

    typedef struct {
        logic [255:0] digest;
        logic [31:0]  nonce;
        logic         found;
        int           cycles;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [607:0] hdr;
    logic [255:0] tgt;
    logic [255:0] digest;
    logic [31:0]  golden_nonce;
    logic         finish;
    logic         found;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];

    btc_miner_top dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .blockHeader_noNonce(hdr),
        .target(tgt),
        .digest(digest),
        .golden_nonce(golden_nonce),
        .finish(finish),
        .found(found)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  x1, x2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [255:0] sha256d(input logic [607:0] hd, input logic [31:0] n);
        logic [255:0] mid, h1;
        mid = comp(IV, hd[607:96]);
        h1  = comp(mid, {hd[95:0], n[7:0], n[15:8], n[23:16], n[31:24], 32'h80000000, 320'd0, 32'd640});
        return comp(IV, {h1, 32'h80000000, 192'd0, 32'd256});
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_digest", digest, '0);
        chk("reset_nonce", 256'(golden_nonce), '0);
        chk("reset_finish", 256'(finish), '0);
        chk("reset_found", 256'(found), '0);
        reset = 1'b0;
    endtask

    // Inputs are scrambled right after start is sampled; the search must use the latched copies.
    task automatic search(input logic [255:0] t, input int hold, input exp_t e, input logic [255:0] prev);
        exp_t g;
        int   n;
        sb.push_back(e);
        @(negedge clk);
        hdr   = HDR;
        tgt   = t;
        start = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < e.cycles + 20) begin
            @(negedge clk);
            start = (n + 1 < hold);
            hdr   = ~HDR;
            tgt   = '0;
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                chk("finish_low_after_start", 256'(finish), '0);
                chk("digest_held_during_search", digest, prev);
            end
            if (finish) break;
        end
        @(negedge clk);
        start = 1'b0;
        g = sb.pop_front();
        if (!finish) begin
            checks++;
            errors++;
            $display("FAIL timeout: finish not seen within %0d cycles, want %0d", n, g.cycles);
        end else begin
            chk("latency", 256'(n), 256'(g.cycles));
            chk("digest", digest, g.digest);
            chk("golden_nonce", 256'(golden_nonce), 256'(g.nonce));
            chk("found", 256'(found), 256'(g.found));
            if (g.found) chk("digest_le_target", 256'(digest <= t), 256'd1);
        end
    endtask

    initial begin
        vec_t         vt [4];
        logic [255:0] t2, d2;
        int           n2;
        reset = 1'b1;
        start = 1'b0;
        hdr   = HDR;
        tgt   = '0;
        t2 = D0 - 256'd1;
        n2 = 0;
        d2 = sha256d(HDR, 0);
        while (n2 < 32 && d2 > t2) begin
            n2++;
            d2 = sha256d(HDR, 32'(n2));
        end
        vt[0] = '{tgt: ONES, hold: 1,  digest: D0, nonce: 32'd0,     found: 1'b1, cycles: 196};
        vt[1] = '{tgt: t2,   hold: 1,  digest: d2, nonce: 32'(n2),   found: 1'b1, cycles: 196 + 131 * n2};
        vt[2] = '{tgt: D0,   hold: 1,  digest: D0, nonce: 32'd0,     found: 1'b1, cycles: 196};
        vt[3] = '{tgt: ONES, hold: 50, digest: D0, nonce: 32'd0,     found: 1'b1, cycles: 196};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            search(vt[i].tgt, vt[i].hold,
                   '{digest: vt[i].digest, nonce: vt[i].nonce, found: vt[i].found, cycles: vt[i].cycles}, '0);
        end
        search(ONES, 1, '{digest: D0, nonce: 32'd0, found: 1'b1, cycles: 196}, D0);
        @(negedge clk);
        hdr   = HDR;
        tgt   = ONES;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midsearch_reset_digest", digest, '0);
        chk("midsearch_reset_nonce", 256'(golden_nonce), '0);
        chk("midsearch_reset_finish", 256'(finish), '0);
        chk("midsearch_reset_found", 256'(found), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        search(ONES, 1, '{digest: D0, nonce: 32'd0, found: 1'b1, cycles: 196}, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
